// File: rtl/pipe_pkg.sv
// Shared pipeline types: the scoreboard entry record and the stage index constants.
// Entries carry a fixed-width register field so one struct serves every ADDR_W up to 8.
package pipe_pkg;

  localparam int STG_EXEC  = 1;
  localparam int STG_MEM   = 2;
  localparam int STG_WB    = 3;
  localparam int SB_ADDR_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] rd_addr;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between decode and the hazard scoreboard.
// Decode drives the master side; the scoreboard answers with stall, accept and forwarding selects.
interface hazard_scoreboard_if #(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int STAGES  = 3
);
  localparam int SW = $clog2(STAGES + 1);

  logic                      issue_valid_i;
  logic                      issue_rd_en_i;
  logic [ADDR_W-1:0]         issue_rd_addr_i;
  logic                      issue_is_load_i;
  logic [NUM_SRC-1:0]        src_en_i;
  logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
  logic                      flush_i;
  logic                      issue_accept_o;
  logic                      stall_o;
  logic [NUM_SRC*SW-1:0]     fwd_sel_o;

  modport master (
    output issue_valid_i, issue_rd_en_i, issue_rd_addr_i, issue_is_load_i,
    output src_en_i, src_addr_i, flush_i,
    input  issue_accept_o, stall_o, fwd_sel_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_en_i, issue_rd_addr_i, issue_is_load_i,
    input  src_en_i, src_addr_i, flush_i,
    output issue_accept_o, stall_o, fwd_sel_o
  );

endinterface

// File: rtl/hazard_match.sv
// Youngest-match finder for one source operand over the in-flight scoreboard entries.
// Reports the forwarding stage and whether that producer is a load whose data is not yet available.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int ADDR_W           = 4,
  parameter int STAGES           = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SW               = 2
) (
  input  logic                   i_src_en,
  input  logic [ADDR_W-1:0]      i_src_addr,
  input  sb_entry_t [STAGES:1]   i_entries,
  output logic [SW-1:0]          o_sel,
  output logic                   o_blocked
);

  // Scan oldest to youngest so the last hit, the lowest stage, decides the result.
  always_comb begin
    o_sel     = '0;
    o_blocked = 1'b0;
    for (int s = STAGES; s >= 1; s--) begin
      if (i_src_en && i_entries[s].valid &&
          (i_entries[s].rd_addr == SB_ADDR_W'(i_src_addr))) begin
        o_sel     = SW'(s);
        o_blocked = i_entries[s].is_load && (s < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks destination registers of in-flight instructions,
// raises the load-use stall, selects forwarding sources and keeps stall statistics.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 4,
  parameter int NUM_SRC          = 2,
  parameter int STAGES           = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int STALL_MAX        = 4
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  hazard_scoreboard_if.slave    bus,
  output logic [2**ADDR_W-1:0]  pending_o,
  output logic [7:0]            stall_run_o,
  output logic [15:0]           stall_total_o,
  output logic                  err_stall_o
);

  localparam int SW = $clog2(STAGES + 1);

  sb_entry_t [STAGES:1]   r_entries;
  sb_entry_t              w_issue_entry;
  logic [NUM_SRC-1:0]     w_blocked;
  logic [NUM_SRC*SW-1:0]  w_fwd_sel;
  logic                   w_stall;
  logic                   w_accept;
  logic [7:0]             r_run;
  logic [7:0]             w_run_next;
  logic [15:0]            r_total;
  logic                   r_err;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_match #(
      .ADDR_W           (ADDR_W),
      .STAGES           (STAGES),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SW               (SW)
    ) u_match (
      .i_src_en   (bus.src_en_i[k]),
      .i_src_addr (bus.src_addr_i[k*ADDR_W +: ADDR_W]),
      .i_entries  (r_entries),
      .o_sel      (w_fwd_sel[k*SW +: SW]),
      .o_blocked  (w_blocked[k])
    );
  end

  // A flush squashes the decode instruction, so it can neither stall nor issue.
  always_comb begin
    w_stall  = bus.issue_valid_i & ~bus.flush_i & (|w_blocked);
    w_accept = bus.issue_valid_i & ~w_stall & ~bus.flush_i;
    w_issue_entry = '0;
    if (w_accept && bus.issue_rd_en_i) begin
      w_issue_entry.valid   = 1'b1;
      w_issue_entry.rd_addr = SB_ADDR_W'(bus.issue_rd_addr_i);
      w_issue_entry.is_load = bus.issue_is_load_i;
    end
  end

  assign bus.stall_o        = w_stall;
  assign bus.issue_accept_o = w_accept;
  assign bus.fwd_sel_o      = w_fwd_sel;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_entries <= '0;
    end else begin
      r_entries[STG_EXEC] <= w_issue_entry;
      for (int s = STG_EXEC + 1; s <= STAGES; s++) begin
        r_entries[s] <= r_entries[s-1];
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int s = 1; s <= STAGES; s++) begin
      if (r_entries[s].valid) begin
        pending_o[r_entries[s].rd_addr[ADDR_W-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_run_next = 8'd0;
    if (w_stall) begin
      w_run_next = (r_run == 8'hFF) ? r_run : r_run + 8'd1;
    end
  end

  // The watchdog latches on the same edge that brings the run count up to its limit.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_run   <= 8'd0;
      r_total <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_run <= w_run_next;
      if (w_stall && (r_total != 16'hFFFF)) begin
        r_total <= r_total + 16'd1;
      end
      if (w_stall && (int'(w_run_next) >= STALL_MAX)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign stall_run_o   = r_run;
  assign stall_total_o = r_total;
  assign err_stall_o   = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default-configured instance driven by a vector table and random
// traffic against an in-flight queue model, plus a deep-load instance exercising the stall watchdog.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

  localparam int A_STAGES    = 3;
  localparam int A_LRS       = 2;
  localparam int A_STALL_MAX = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(4), .NUM_SRC(2), .STAGES(A_STAGES)) busA ();
  hazard_scoreboard_if #(.ADDR_W(4), .NUM_SRC(2), .STAGES(4)) busB ();

  logic [15:0] pendA, pendB;
  logic [7:0]  runA, runB;
  logic [15:0] totalA, totalB;
  logic        errA, errB;

  hazard_scoreboard #(
    .DATA_W(32), .ADDR_W(4), .NUM_SRC(2), .STAGES(A_STAGES),
    .LOAD_READY_STAGE(A_LRS), .STALL_MAX(A_STALL_MAX)
  ) dutA (
    .clk_i(clk), .nreset_i(nreset), .bus(busA),
    .pending_o(pendA), .stall_run_o(runA), .stall_total_o(totalA), .err_stall_o(errA)
  );

  hazard_scoreboard #(
    .DATA_W(32), .ADDR_W(4), .NUM_SRC(2), .STAGES(4),
    .LOAD_READY_STAGE(4), .STALL_MAX(2)
  ) dutB (
    .clk_i(clk), .nreset_i(nreset), .bus(busB),
    .pending_o(pendB), .stall_run_o(runB), .stall_total_o(totalB), .err_stall_o(errB)
  );

  int nChecks = 0;
  int nFails  = 0;

  // In-flight instruction record: age is the number of edges since it issued (age 1 = execute).
  typedef struct {
    int rd;
    bit ld;
    int age;
  } flight_t;

  flight_t inflight[$];
  int mRun = 0;
  int mTotal = 0;
  bit mErr = 1'b0;
  bit mStall, mAccept;
  int mFwd[2];
  logic [15:0] mPend;

  bit sValid, sRdEn, sLd, sFlush;
  int sRd;
  bit sEn[2];
  int sAddr[2];

  typedef struct {
    bit valid; bit rdEn; int rd; bit ld;
    bit s0en; int s0; bit s1en; int s1; bit flush;
    bit expStall; bit expAccept; int expFwd0; int expFwd1; int expPend;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input bit rdEn, input int rd, input bit ld,
                               input bit s0en, input int s0, input bit s1en, input int s1,
                               input bit flush);
    sValid = valid; sRdEn = rdEn; sRd = rd; sLd = ld;
    sEn[0] = s0en; sAddr[0] = s0; sEn[1] = s1en; sAddr[1] = s1; sFlush = flush;
    busA.issue_valid_i   = valid;
    busA.issue_rd_en_i   = rdEn;
    busA.issue_rd_addr_i = 4'(rd);
    busA.issue_is_load_i = ld;
    busA.src_en_i        = {s1en, s0en};
    busA.src_addr_i      = {4'(s1), 4'(s0)};
    busA.flush_i         = flush;
  endtask

  task automatic driveB(input bit valid, input bit rdEn, input int rd, input bit ld,
                        input bit s0en, input int s0);
    busB.issue_valid_i   = valid;
    busB.issue_rd_en_i   = rdEn;
    busB.issue_rd_addr_i = 4'(rd);
    busB.issue_is_load_i = ld;
    busB.src_en_i        = {1'b0, s0en};
    busB.src_addr_i      = {4'd0, 4'(s0)};
    busB.flush_i         = 1'b0;
  endtask

  // Youngest in-flight producer per source; a load younger than its ready stage blocks issue.
  task automatic modelEval();
    bit blocked = 1'b0;
    mPend = '0;
    foreach (inflight[i]) mPend[inflight[i].rd] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int best = 0;
      bit bestLd = 1'b0;
      foreach (inflight[i]) begin
        if (sEn[k] && inflight[i].rd == sAddr[k] && (best == 0 || inflight[i].age < best)) begin
          best = inflight[i].age;
          bestLd = inflight[i].ld;
        end
      end
      mFwd[k] = best;
      if (best != 0 && bestLd && best < A_LRS) blocked = 1'b1;
    end
    mStall  = sValid && !sFlush && blocked;
    mAccept = sValid && !mStall && !sFlush;
  endtask

  task automatic modelAdvance();
    flight_t f;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      f = inflight[i];
      f.age++;
      if (f.age > A_STAGES) inflight.delete(i);
      else inflight[i] = f;
    end
    if (mAccept && sRdEn) begin
      f.rd = sRd; f.ld = sLd; f.age = 1;
      inflight.push_back(f);
    end
    if (mStall) begin
      mRun   = (mRun < 255) ? mRun + 1 : 255;
      mTotal = (mTotal < 65535) ? mTotal + 1 : 65535;
      if (mRun >= A_STALL_MAX) mErr = 1'b1;
    end else begin
      mRun = 0;
    end
  endtask

  // Inputs are already applied; compare against the model, then cross one clock edge.
  task automatic cycleA();
    #2;
    modelEval();
    checkOutput("stall", int'(busA.stall_o), int'(mStall));
    checkOutput("accept", int'(busA.issue_accept_o), int'(mAccept));
    if (!mStall) begin
      checkOutput("fwd0", int'(busA.fwd_sel_o[1:0]), mFwd[0]);
      checkOutput("fwd1", int'(busA.fwd_sel_o[3:2]), mFwd[1]);
    end
    checkOutput("pending", int'(pendA), int'(mPend));
    checkOutput("stall_run", int'(runA), mRun);
    checkOutput("stall_total", int'(totalA), mTotal);
    checkOutput("err_stall", int'(errA), int'(mErr));
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    driveB(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Deep-load instance: three stall cycles, watchdog rises after the second.
    driveB(1, 1, 6, 1, 0, 0);
    #2;
    checkOutput("B ldr accept", int'(busB.issue_accept_o), 1);
    checkOutput("B ldr stall", int'(busB.stall_o), 0);
    @(posedge clk); @(negedge clk);
    driveB(1, 1, 7, 0, 1, 6);
    #2;
    checkOutput("B stall1", int'(busB.stall_o), 1);
    checkOutput("B accept1", int'(busB.issue_accept_o), 0);
    checkOutput("B pending", int'(pendB), 16'h0040);
    checkOutput("B err pre", int'(errB), 0);
    @(posedge clk); @(negedge clk);
    #2;
    checkOutput("B stall2", int'(busB.stall_o), 1);
    checkOutput("B run1", int'(runB), 1);
    checkOutput("B err after 1", int'(errB), 0);
    @(posedge clk); @(negedge clk);
    #2;
    checkOutput("B stall3", int'(busB.stall_o), 1);
    checkOutput("B run2", int'(runB), 2);
    checkOutput("B err after 2", int'(errB), 1);
    @(posedge clk); @(negedge clk);
    #2;
    checkOutput("B issue stall", int'(busB.stall_o), 0);
    checkOutput("B issue accept", int'(busB.issue_accept_o), 1);
    checkOutput("B issue fwd", int'(busB.fwd_sel_o[2:0]), 4);
    checkOutput("B total3", int'(totalB), 3);
    @(posedge clk); @(negedge clk);
    driveB(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("B run clear", int'(runB), 0);
    checkOutput("B total held", int'(totalB), 3);
    checkOutput("B err sticky", int'(errB), 1);
    @(negedge clk);

    vecs[0]  = '{1,1,1,0, 0,0,0,0, 0, 0,1,0,0,                 16'h0000};
    vecs[1]  = '{1,1,2,0, 1,1,0,0, 0, 0,1,STG_EXEC,0,          16'h0002};
    vecs[2]  = '{1,1,3,1, 1,2,1,1, 0, 0,1,STG_EXEC,STG_MEM,    16'h0006};
    vecs[3]  = '{1,1,4,0, 1,3,0,0, 0, 1,0,STG_EXEC,0,          16'h000E};
    vecs[4]  = '{1,1,4,0, 1,3,0,0, 0, 0,1,STG_MEM,0,           16'h000C};
    vecs[5]  = '{1,1,5,0, 0,0,0,0, 0, 0,1,0,0,                 16'h0018};
    vecs[6]  = '{1,1,5,0, 1,4,0,0, 0, 0,1,STG_MEM,0,           16'h0030};
    vecs[7]  = '{1,0,0,0, 1,5,1,4, 0, 0,1,STG_EXEC,STG_WB,     16'h0030};
    vecs[8]  = '{1,1,6,1, 0,0,0,0, 0, 0,1,0,0,                 16'h0020};
    vecs[9]  = '{1,1,8,0, 1,6,0,0, 1, 0,0,STG_EXEC,0,          16'h0060};
    vecs[10] = '{1,0,0,0, 1,8,1,6, 0, 0,1,0,STG_MEM,           16'h0040};
    vecs[11] = '{1,0,0,0, 0,6,1,6, 0, 0,1,0,STG_WB,            16'h0040};

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].rdEn, vecs[i].rd, vecs[i].ld,
                    vecs[i].s0en, vecs[i].s0, vecs[i].s1en, vecs[i].s1, vecs[i].flush);
      #1;
      checkOutput($sformatf("vec%0d stall", i), int'(busA.stall_o), int'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d accept", i), int'(busA.issue_accept_o), int'(vecs[i].expAccept));
      checkOutput($sformatf("vec%0d fwd0", i), int'(busA.fwd_sel_o[1:0]), vecs[i].expFwd0);
      checkOutput($sformatf("vec%0d fwd1", i), int'(busA.fwd_sel_o[3:2]), vecs[i].expFwd1);
      checkOutput($sformatf("vec%0d pending", i), int'(pendA), vecs[i].expPend);
      cycleA();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("A total after table", int'(totalA), 1);
    checkOutput("A run after table", int'(runA), 0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom % 4 != 0, $urandom % 4 != 0, $urandom_range(0, 5), $urandom % 3 == 0,
                    1'($urandom), $urandom_range(0, 5), 1'($urandom), $urandom_range(0, 5),
                    $urandom % 8 == 0);
      cycleA();
    end

    // Asynchronous reset with a live entry that would otherwise forward to source 0.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    cycleA();
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0);
    #2;
    checkOutput("pre-reset fwd0", int'(busA.fwd_sel_o[1:0]), STG_EXEC);
    checkOutput("pre-reset pend1", int'(pendA[1]), 1);
    nreset = 1'b0;
    #1;
    checkOutput("reset stall", int'(busA.stall_o), 0);
    checkOutput("reset accept", int'(busA.issue_accept_o), 0);
    checkOutput("reset fwd", int'(busA.fwd_sel_o), 0);
    checkOutput("reset pending", int'(pendA), 0);
    checkOutput("reset run", int'(runA), 0);
    checkOutput("reset total", int'(totalA), 0);
    checkOutput("reset err", int'(errA), 0);
    checkOutput("reset B err", int'(errB), 0);
    inflight.delete();
    mRun = 0; mTotal = 0; mErr = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycleA();
    applyStimulus(1, 1, 3, 1, 0, 0, 0, 0, 0);
    cycleA();
    applyStimulus(1, 1, 4, 0, 1, 3, 0, 0, 0);
    cycleA();
    cycleA();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
